bst_axi_ram: RTL and testbench



---
 rtl/bst_axi_ram.sv | 230 +++++++++++++++++++++++
 tb/tb_bst_axi_ram.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bst_axi_ram.sv
// AXI4 slave RAM holding the binary-tree nodes: one single-port word array,
// one read or write beat per cycle, with round-robin arbitration between whole bursts.
module bst_axi_ram #(
    parameter int RAM_DATA_WIDTH = 128,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int RAM_STRB_WIDTH = RAM_DATA_WIDTH / 8,
    parameter int RAM_ID_WIDTH   = 8,
    parameter int RAM_DEPTH_LOG2 = 10
) (
    input  logic                      aclk,
    input  logic                      areset,

    input  logic [RAM_ID_WIDTH-1:0]   ram_axi_awid,
    input  logic [RAM_ADDR_WIDTH-1:0] ram_axi_awaddr,
    input  logic [7:0]                ram_axi_awlen,
    input  logic [2:0]                ram_axi_awsize,
    input  logic [1:0]                ram_axi_awburst,
    input  logic                      ram_axi_awlock,
    input  logic [3:0]                ram_axi_awcache,
    input  logic [2:0]                ram_axi_awprot,
    input  logic                      ram_axi_awvalid,
    output logic                      ram_axi_awready,

    input  logic [RAM_DATA_WIDTH-1:0] ram_axi_wdata,
    input  logic [RAM_STRB_WIDTH-1:0] ram_axi_wstrb,
    input  logic                      ram_axi_wlast,
    input  logic                      ram_axi_wvalid,
    output logic                      ram_axi_wready,

    output logic [RAM_ID_WIDTH-1:0]   ram_axi_bid,
    output logic [1:0]                ram_axi_bresp,
    output logic                      ram_axi_bvalid,
    input  logic                      ram_axi_bready,

    input  logic [RAM_ID_WIDTH-1:0]   ram_axi_arid,
    input  logic [RAM_ADDR_WIDTH-1:0] ram_axi_araddr,
    input  logic [7:0]                ram_axi_arlen,
    input  logic [2:0]                ram_axi_arsize,
    input  logic [1:0]                ram_axi_arburst,
    input  logic                      ram_axi_arlock,
    input  logic [3:0]                ram_axi_arcache,
    input  logic [2:0]                ram_axi_arprot,
    input  logic                      ram_axi_arvalid,
    output logic                      ram_axi_arready,

    output logic [RAM_ID_WIDTH-1:0]   ram_axi_rid,
    output logic [RAM_DATA_WIDTH-1:0] ram_axi_rdata,
    output logic [1:0]                ram_axi_rresp,
    output logic                      ram_axi_rlast,
    output logic                      ram_axi_rvalid,
    input  logic                      ram_axi_rready
);

    localparam int OFS   = $clog2(RAM_STRB_WIDTH);
    localparam int IDX_W = RAM_DEPTH_LOG2;
    localparam int DEPTH = 1 << RAM_DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRESP, S_READ} state_t;

    state_t                    state_q, state_d;
    logic                      last_rd_q, last_rd_d;
    logic [RAM_ID_WIDTH-1:0]   id_q, id_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [7:0]                len_q, len_d;
    logic [1:0]                burst_q, burst_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic                      ld_done_q, ld_done_d;
    logic                      rvalid_q, rvalid_d;
    logic                      rlast_q, rlast_d;

    logic                      grant_w, grant_r;
    logic                      wr_en, rd_en;
    logic                      last_beat;
    logic [IDX_W-1:0]          idx_adv;
    logic [RAM_DATA_WIDTH-1:0] rdata_raw;

    logic unused_inputs;
    assign unused_inputs = ^{ram_axi_awaddr, ram_axi_araddr, ram_axi_awsize, ram_axi_arsize,
                             ram_axi_awlock, ram_axi_arlock, ram_axi_awcache, ram_axi_arcache,
                             ram_axi_awprot, ram_axi_arprot};

    // Contention goes to whichever channel did not win last time.
    assign grant_w   = ram_axi_awvalid && (!ram_axi_arvalid || last_rd_q);
    assign grant_r   = ram_axi_arvalid && !grant_w;
    assign last_beat = (cnt_q == len_q);
    assign idx_adv   = (burst_q == 2'b00) ? idx_q : idx_q + IDX_W'(1);

    always_comb begin
        state_d         = state_q;
        last_rd_d       = last_rd_q;
        id_d            = id_q;
        idx_d           = idx_q;
        len_d           = len_q;
        burst_d         = burst_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        ld_done_d       = ld_done_q;
        rvalid_d        = rvalid_q;
        rlast_d         = rlast_q;
        ram_axi_awready = 1'b0;
        ram_axi_arready = 1'b0;
        ram_axi_wready  = 1'b0;
        wr_en           = 1'b0;
        rd_en           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_w) begin
                    ram_axi_awready = 1'b1;
                    id_d      = ram_axi_awid;
                    idx_d     = ram_axi_awaddr[OFS +: IDX_W];
                    len_d     = ram_axi_awlen;
                    burst_d   = ram_axi_awburst;
                    cnt_d     = 8'd0;
                    last_rd_d = 1'b0;
                    state_d   = S_WRITE;
                end else if (grant_r) begin
                    ram_axi_arready = 1'b1;
                    id_d      = ram_axi_arid;
                    idx_d     = ram_axi_araddr[OFS +: IDX_W];
                    len_d     = ram_axi_arlen;
                    burst_d   = ram_axi_arburst;
                    cnt_d     = 8'd0;
                    ld_done_d = 1'b0;
                    last_rd_d = 1'b1;
                    state_d   = S_READ;
                end
            end
            S_WRITE: begin
                ram_axi_wready = 1'b1;
                if (ram_axi_wvalid) begin
                    wr_en = 1'b1;
                    idx_d = idx_adv;
                    // Burst length comes from awlen; a wlast that disagrees only flags an error.
                    if (ram_axi_wlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = S_WRESP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_WRESP: begin
                if (ram_axi_bready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (!ld_done_q && (!rvalid_q || ram_axi_rready)) begin
                    rd_en    = 1'b1;
                    rvalid_d = 1'b1;
                    rlast_d  = last_beat;
                    idx_d    = idx_adv;
                    if (last_beat) begin
                        ld_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (ram_axi_rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                end
                if (rvalid_q && ram_axi_rready && rlast_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= S_IDLE;
            last_rd_q <= 1'b1;
            id_q      <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ld_done_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            id_q      <= id_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ld_done_q <= ld_done_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    // One byte-wide array per strobe lane; the read register sits next to each lane.
    for (genvar gi = 0; gi < RAM_STRB_WIDTH; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rdata_q;

        always_ff @(posedge aclk) begin
            if (wr_en && ram_axi_wstrb[gi]) begin
                lane_mem[idx_q] <= ram_axi_wdata[gi*8 +: 8];
            end
            if (rd_en) begin
                lane_rdata_q <= lane_mem[idx_q];
            end
        end

        assign rdata_raw[gi*8 +: 8] = lane_rdata_q;
    end

    assign ram_axi_bvalid = (state_q == S_WRESP);
    assign ram_axi_bresp  = (state_q == S_WRESP && err_q) ? 2'b10 : 2'b00;
    assign ram_axi_bid    = id_q;
    assign ram_axi_rid    = id_q;
    assign ram_axi_rresp  = 2'b00;
    assign ram_axi_rlast  = rlast_q;
    assign ram_axi_rvalid = rvalid_q;
    // The read register is not reset, so hide its contents until a beat is presented.
    assign ram_axi_rdata  = rvalid_q ? rdata_raw : '0;

endmodule

// File: tb/tb_bst_axi_ram.sv
// Directed and randomized bursts against bst_axi_ram, checked against a word-array
// reference model that applies the burst addressing and byte-strobe rules directly.
module tb_bst_axi_ram;
    localparam int DW    = 128;
    localparam int AW    = 16;
    localparam int SW    = DW / 8;
    localparam int IW    = 8;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    logic [IW-1:0] awid, arid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize, awprot, arprot;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awlock, arlock;
    logic [3:0]    awcache, arcache;
    logic          awvalid, awready, arvalid, arready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic          wlast, wvalid, wready, bvalid, bready;
    logic          rlast, rvalid, rready;

    bst_axi_ram dut (
        .aclk(clk), .areset(areset),
        .ram_axi_awid(awid), .ram_axi_awaddr(awaddr), .ram_axi_awlen(awlen),
        .ram_axi_awsize(awsize), .ram_axi_awburst(awburst), .ram_axi_awlock(awlock),
        .ram_axi_awcache(awcache), .ram_axi_awprot(awprot), .ram_axi_awvalid(awvalid),
        .ram_axi_awready(awready),
        .ram_axi_wdata(wdata), .ram_axi_wstrb(wstrb), .ram_axi_wlast(wlast),
        .ram_axi_wvalid(wvalid), .ram_axi_wready(wready),
        .ram_axi_bid(bid), .ram_axi_bresp(bresp), .ram_axi_bvalid(bvalid), .ram_axi_bready(bready),
        .ram_axi_arid(arid), .ram_axi_araddr(araddr), .ram_axi_arlen(arlen),
        .ram_axi_arsize(arsize), .ram_axi_arburst(arburst), .ram_axi_arlock(arlock),
        .ram_axi_arcache(arcache), .ram_axi_arprot(arprot), .ram_axi_arvalid(arvalid),
        .ram_axi_arready(arready),
        .ram_axi_rid(rid), .ram_axi_rdata(rdata), .ram_axi_rresp(rresp),
        .ram_axi_rlast(rlast), .ram_axi_rvalid(rvalid), .ram_axi_rready(rready)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] wbuf [256];
    logic [SW-1:0] sbuf [256];
    logic [DW-1:0] rx_q [$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] ctrl_bits();
        return {awready, arready, wready, bvalid, bresp, bid, rvalid, rlast, rid, rresp};
    endfunction

    // Word touched by beat n of a burst: FIXED stays put, every other type steps by one word.
    function automatic int widx(input logic [AW-1:0] addr, input logic [1:0] burst, input int n);
        int base;
        base = int'(addr) / SW;
        return (base + ((burst == 2'b00) ? 0 : n)) % DEPTH;
    endfunction

    task automatic fill_full(input int n);
        for (int i = 0; i < n; i++) begin
            wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
            sbuf[i] = '1;
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                             input logic [IW-1:0] id, input int last_at, input int abort_at);
        int  n;
        int  w;
        int  hold;
        bit  err;
        awaddr = addr; awlen = 8'(len); awburst = burst; awid = id; awvalid = 1'b1;
        n = 0;
        #1;
        while (!awready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("aw_handshake", awready, 1'b1);
        @(negedge clk);
        awvalid = 1'b0;
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wdata  = wbuf[i];
            wstrb  = sbuf[i];
            wlast  = (last_at < 0) ? (i == len) : (i == last_at);
            wvalid = 1'b1;
            if (wlast != (i == len)) err = 1'b1;
            if (i == abort_at) begin
                areset = 1'b1;
                #1;
                chk("reset_ctrl", ctrl_bits(), '0);
                chk("reset_rdata", rdata, '0);
                wvalid = 1'b0; wlast = 1'b0;
                @(negedge clk);
                areset = 1'b0;
                #1;
                chk("idle_after_reset", {wready, bvalid, rvalid}, '0);
                $display("write addr=%h len=%0d aborted at beat %0d", addr, len, i);
                return;
            end
            #1;
            chk("wready", wready, 1'b1);
            w = widx(addr, burst, i);
            for (int b = 0; b < SW; b++) begin
                if (sbuf[i][b]) ref_mem[w][b*8 +: 8] = wbuf[i][b*8 +: 8];
            end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        #1;
        chk("bvalid_latency", bvalid, 1'b1);
        hold = $urandom_range(0, 2);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk); #1;
            chk("bvalid_hold", bvalid, 1'b1);
        end
        chk("bresp", bresp, err ? 2'b10 : 2'b00);
        chk("bid", bid, id);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        #1;
        chk("bvalid_drop", bvalid, 1'b0);
        $display("write addr=%h len=%0d burst=%0d id=%h bresp=%b", addr, len, burst, id, bresp);
        @(negedge clk);
    endtask

    // mode 0: rready always high; 1: pattern 1,0,0 repeating; 2: random
    task automatic axi_read(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                            input logic [IW-1:0] id, input int mode);
        int            n, beat, cyc;
        bit            hold;
        logic [DW-1:0] held;
        rx_q.delete();
        araddr = addr; arlen = 8'(len); arburst = burst; arid = id; arvalid = 1'b1;
        n = 0;
        #1;
        while (!arready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("ar_handshake", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        beat = 0; cyc = 0; hold = 1'b0; held = '0;
        while (beat <= len && cyc < 400) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 3 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (cyc == 0) chk("rvalid_first_0", rvalid, 1'b0);
            if (cyc == 1) chk("rvalid_first_1", rvalid, 1'b1);
            if (mode == 0 && cyc >= 1) chk("r_throughput", rvalid, 1'b1);
            if (hold) begin
                chk("r_hold_valid", rvalid, 1'b1);
                chk("r_hold_data", rdata, held);
            end
            hold = 1'b0;
            if (rvalid && rready) begin
                rx_q.push_back(rdata);
                chk("rdata", rdata, ref_mem[widx(addr, burst, beat)]);
                chk("rlast", rlast, (beat == len));
                chk("rid", rid, id);
                beat++;
            end else if (rvalid) begin
                hold = 1'b1;
                held = rdata;
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        chk("r_beats", beat, len + 1);
        #1;
        chk("rvalid_end", rvalid, 1'b0);
        $display("read  addr=%h len=%0d burst=%0d id=%h beats=%0d cycles=%0d", addr, len, burst, id, beat, cyc);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] old2, old3;
        logic [AW-1:0] ra;
        int            rl, lat;
        logic [1:0]    rb;

        areset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd4; awburst = 2'b01; awlock = 1'b0;
        awcache = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd4; arburst = 2'b01; arlock = 1'b0;
        arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl_init", ctrl_bits(), '0);
        chk("reset_rdata_init", rdata, '0);
        @(negedge clk);
        areset = 1'b0;
        #1;
        chk("idle_ctrl", ctrl_bits(), '0);
        @(negedge clk);

        // First contention after reset favours write.
        awaddr = 16'h0200; araddr = 16'h0200; awvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("contend1_awready", awready, 1'b1);
        chk("contend1_arready", arready, 1'b0);
        awvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        fill_full(3);
        axi_write(16'h0200, 2, 2'b01, 8'h11, 1, -1);
        chk("early_wlast_bresp_seen", ref_mem[widx(16'h0200, 2'b01, 2)], wbuf[2]);

        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("contend2_arready", arready, 1'b1);
        chk("contend2_awready", awready, 1'b0);
        awvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        axi_read(16'h0200, 2, 2'b01, 8'h22, 0);

        // Give every word a known value.
        for (int c = 0; c < 4; c++) begin
            fill_full(256);
            axi_write(AW'(c * 256 * SW), 255, 2'b01, 8'(c), -1, -1);
        end

        wbuf[0] = {16{8'hA5}}; sbuf[0] = '1;
        axi_write(16'h0040, 0, 2'b01, 8'h5A, -1, -1);
        axi_read(16'h0040, 0, 2'b01, 8'h3C, 0);
        chk("single_rdata", rx_q[0], {16{8'hA5}});

        for (int i = 0; i < 4; i++) begin
            wbuf[i] = DW'(i + 1); sbuf[i] = '1;
        end
        axi_write(16'h0100, 3, 2'b01, 8'h01, -1, -1);
        axi_read(16'h0100, 3, 2'b01, 8'h02, 0);
        for (int i = 0; i < 4; i++) chk("incr_beat", rx_q[i], DW'(i + 1));
        axi_read(16'h0100, 2, 2'b00, 8'h03, 0);
        for (int i = 0; i < 3; i++) chk("fixed_beat", rx_q[i], DW'(1));

        wbuf[0] = '1; sbuf[0] = '1;
        axi_write(16'h0500, 0, 2'b01, 8'h04, -1, -1);
        wbuf[0] = '0; sbuf[0] = 16'h0001;
        axi_write(16'h0500, 0, 2'b01, 8'h05, -1, -1);
        axi_read(16'h0500, 0, 2'b01, 8'h06, 0);
        chk("strobe_byte0", rx_q[0], {{15{8'hFF}}, 8'h00});

        fill_full(4);
        axi_write(16'h0600, 3, 2'b01, 8'h07, -1, -1);
        axi_read(16'h0600, 3, 2'b01, 8'h08, 1);

        // INCR burst that runs off the top word wraps to word 0.
        fill_full(4);
        axi_write(16'hFFE0, 3, 2'b01, 8'h09, -1, -1);
        axi_read(16'h3FE0, 3, 2'b10, 8'h0A, 0);
        chk("wrap_word0", rx_q[2], wbuf[2]);

        old2 = ref_mem[widx(16'h0700, 2'b01, 2)];
        old3 = ref_mem[widx(16'h0700, 2'b01, 3)];
        fill_full(4);
        axi_write(16'h0700, 3, 2'b01, 8'h0B, -1, 2);
        axi_read(16'h0700, 3, 2'b01, 8'h0C, 0);
        chk("abort_beat0", rx_q[0], wbuf[0]);
        chk("abort_beat2_kept", rx_q[2], old2);
        chk("abort_beat3_kept", rx_q[3], old3);

        for (int t = 0; t < 25; t++) begin
            ra = AW'($urandom);
            rl = $urandom_range(0, 7);
            rb = 2'($urandom_range(0, 3));
            lat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rl) : -1;
            for (int i = 0; i <= rl; i++) begin
                wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
                sbuf[i] = SW'($urandom);
            end
            axi_write(ra, rl, rb, 8'($urandom), lat, -1);
            axi_read(ra, rl, rb, 8'($urandom), 2);
            axi_read(AW'($urandom), $urandom_range(0, 7), 2'($urandom_range(0, 3)), 8'($urandom), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
